// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Freeze/flush sequencer for the 5-stage pipeline. It freezes the whole pipe
// during SRAM waits. It flushes IF/ID and ID/EX on taken branches, deferring
// a flush that arrives while frozen. It stalls the front end on data hazards.
// A saturating counter tracks the cycles in which the PC was held.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   src1/src2, *_vld   ID-stage source operands and their use flags
//   exe_*/mem_*        destination, writeback and load info from EXE / MEM
//   fwd_en             forwarding present; only load-use hazards stall
//   branch_taken       taken branch resolved in EXE
//   mem_req/mem_ready  SRAM handshake from MEM
//   pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze  controls
//   stall_count        saturating count of pc_freeze cycles
module pipeline_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             src1_vld,
  input  logic             two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MEM_WAIT = 1'b1;

  logic st;
  logic br_pend;
  logic mem_stall, hazard, br;
  logic exe_hit, mem_hit;

  assign mem_stall = (st == ST_RUN      && mem_req && !mem_ready) ||
                     (st == ST_MEM_WAIT && !mem_ready);

  assign exe_hit = (src1_vld && src1 == exe_dest) || (two_src && src2 == exe_dest);
  assign mem_hit = (src1_vld && src1 == mem_dest) || (two_src && src2 == mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard = fwd_en ? (exe_mem_read && exe_wb_en && exe_hit)
                         : ((exe_wb_en && exe_hit) || (mem_wb_en && mem_hit));

  assign br = branch_taken || br_pend;

  always_comb begin
    pc_freeze    = 1'b0;
    if_id_freeze = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        pipe_freeze  = 1'b1;
      end else if (br) begin
        // The instruction in ID is squashed, so its hazard does not matter.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_freeze    = 1'b1;
        if_id_freeze = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= ST_RUN;
      br_pend     <= 1'b0;
      stall_count <= '0;
    end else begin
      case (st)
        ST_RUN:      if (mem_req && !mem_ready) st <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_ready)             st <= ST_RUN;
        default:                                st <= ST_RUN;
      endcase
      // IF/ID ignores flush while frozen. Remember the branch until the
      // first unfrozen cycle, which is also the cycle the flush goes out.
      if (branch_taken && mem_stall) br_pend <= 1'b1;
      else if (!mem_stall)           br_pend <= 1'b0;
      if (pc_freeze && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
    logic src1_vld, two_src, exe_wb_en, exe_mem_read, mem_wb_en, fwd_en;
    logic branch_taken, mem_req, mem_ready;
  } in_t;

  // exp = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze}
  typedef struct {
    in_t        in;
    logic [4:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [4:0]       exp;
    logic [CNT_W-1:0] cnt;
    string            name;
  } sb_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic src1_vld, two_src, exe_wb_en, exe_mem_read, mem_wb_en, fwd_en;
  logic branch_taken, mem_req, mem_ready;
  logic pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze;
  logic [CNT_W-1:0] stall_count;

  int total = 0, bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  sb_t sbq[$];

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .src1_vld(src1_vld),
    .two_src(two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_freeze(pipe_freeze), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(logic [3:0] s1, logic v1, logic [3:0] s2, logic v2,
                             logic [3:0] ed, logic ew, logic er,
                             logic [3:0] md, logic mw, logic fw,
                             logic bt, logic rq, logic rd);
    in_t t;
    t.src1 = s1; t.src1_vld = v1; t.src2 = s2; t.two_src = v2;
    t.exe_dest = ed; t.exe_wb_en = ew; t.exe_mem_read = er;
    t.mem_dest = md; t.mem_wb_en = mw; t.fwd_en = fw;
    t.branch_taken = bt; t.mem_req = rq; t.mem_ready = rd;
    return t;
  endfunction

  task automatic apply(input in_t t);
    src1 = t.src1; src1_vld = t.src1_vld; src2 = t.src2; two_src = t.two_src;
    exe_dest = t.exe_dest; exe_wb_en = t.exe_wb_en; exe_mem_read = t.exe_mem_read;
    mem_dest = t.mem_dest; mem_wb_en = t.mem_wb_en; fwd_en = t.fwd_en;
    branch_taken = t.branch_taken; mem_req = t.mem_req; mem_ready = t.mem_ready;
  endtask

  task automatic check_now(input logic [4:0] e, input logic [CNT_W-1:0] c, input string nm);
    logic [4:0] got;
    got = {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s outs: got %b want %b", nm, got, e);
    end
    total++;
    if (stall_count !== c) begin
      bad++;
      $display("FAIL %s stall_count: got %0d want %0d", nm, stall_count, c);
    end
  endtask

  // Drive on the falling edge, compare mid-low-phase, then advance the
  // expected counter across the rising edge.
  task automatic step(input in_t t, input logic [4:0] e, input string nm);
    sb_t s;
    @(negedge clk);
    apply(t);
    sbq.push_back('{exp: e, cnt: exp_cnt, name: nm});
    #2;
    s = sbq.pop_front();
    check_now(s.exp, s.cnt, s.name);
    @(posedge clk);
    if (e[4] && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
  endtask

  in_t  idle, haz, wait_c, wait_br, rel;
  vec_t vt[12];

  initial begin
    idle    = mk(0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
    haz     = mk(3,1,0,0, 3,1,0, 0,0,0, 0,0,0);
    wait_c  = mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,0);
    wait_br = mk(0,0,0,0, 0,0,0, 0,0,0, 1,1,0);
    rel     = mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,1);

    vt[0]  = '{idle,                                  5'b00000, "idle"};
    vt[1]  = '{haz,                                   5'b11010, "fwd0_exe_src1"};
    vt[2]  = '{mk(3,1,0,0, 3,1,0, 0,0,1, 0,0,0),      5'b00000, "fwd1_no_load"};
    vt[3]  = '{mk(3,1,0,0, 3,1,1, 0,0,1, 0,0,0),      5'b11010, "fwd1_load_use"};
    vt[4]  = '{mk(1,0,5,1, 2,1,0, 5,1,0, 0,0,0),      5'b11010, "fwd0_mem_src2"};
    vt[5]  = '{mk(1,0,5,0, 5,1,0, 5,1,0, 0,0,0),      5'b00000, "src2_unused"};
    vt[6]  = '{mk(7,0,0,0, 7,1,0, 7,1,0, 0,0,0),      5'b00000, "src1_unused"};
    vt[7]  = '{mk(3,1,0,0, 3,0,0, 0,0,0, 0,0,0),      5'b00000, "exe_no_wb"};
    vt[8]  = '{mk(6,1,0,0, 1,1,1, 6,1,1, 0,0,0),      5'b00000, "fwd1_mem_only"};
    vt[9]  = '{mk(3,1,0,0, 3,1,0, 0,0,0, 1,0,0),      5'b00110, "branch_over_haz"};
    vt[10] = '{rel,                                   5'b00000, "req_ready_same"};
    vt[11] = '{idle,                                  5'b00000, "after_req_run"};

    // Reset state: outputs gated low even with a hazard present.
    apply(haz);
    #3 check_now(5'b00000, '0, "reset_state");
    apply(idle);
    @(negedge clk) rst = 1'b1;

    foreach (vt[i]) step(vt[i].in, vt[i].exp, vt[i].name);

    // Three wait cycles, release, back in RUN.
    for (int i = 0; i < 3; i++) step(wait_c, 5'b11001, "mem_wait");
    step(rel,  5'b00000, "mem_release");
    step(idle, 5'b00000, "mem_run_again");

    // Branch in the 2nd wait cycle is deferred to the release cycle.
    step(wait_c,  5'b11001, "brw_wait1");
    step(wait_br, 5'b11001, "brw_wait2_br");
    step(wait_c,  5'b11001, "brw_wait3");
    step(rel,     5'b00110, "brw_release_flush");
    step(idle,    5'b00000, "brw_pend_cleared");

    // Saturation: counter sticks at all-ones.
    for (int i = 0; i < 20; i++) step(haz, 5'b11010, "sat_haz");
    step(idle, 5'b00000, "sat_hold");

    // Asynchronous reset in MEM_WAIT with a branch pending.
    step(wait_c,  5'b11001, "rst_wait1");
    step(wait_br, 5'b11001, "rst_wait2_br");
    @(negedge clk);
    apply(wait_c);
    #2 rst = 1'b0;
    exp_cnt = '0;
    #1 check_now(5'b00000, '0, "rst_async");
    apply(idle);
    @(negedge clk) rst = 1'b1;
    step(idle, 5'b00000, "rst_back_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central freeze/flush sequencer for the 5-stage ARM pipeline. It drives the PC register and the IF/ID register, and bubbles the ID/EX register. Inputs are data hazards (ID sources against EXE/MEM destinations), taken branches from EXE, and the SRAM wait handshake from MEM. A memory-wait state machine freezes the whole pipe. Branch flushes that arrive during a freeze are held pending, because the IF/ID register ignores flush while frozen. A saturating counter records stall cycles for performance debug.

## Interface
- REG_W, 4, register-index width
- CNT_W, 16, stall-counter width
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- src1  in  REG_W  ID-stage first source register
- src2  in  REG_W  ID-stage second source register
- src1_vld  in  1  ID instruction reads src1
- two_src  in  1  ID instruction reads src2
- exe_dest  in  REG_W  EXE-stage destination register
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  REG_W  MEM-stage destination register
- mem_wb_en  in  1  MEM instruction writes back
- fwd_en  in  1  forwarding unit active; only load-use hazards stall
- branch_taken  in  1  EXE resolved a taken branch this cycle
- mem_req  in  1  MEM stage performing load/store
- mem_ready  in  1  SRAM access complete
- pc_freeze  out  1  hold PC
- if_id_freeze  out  1  hold IF/ID register
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_count  out  CNT_W  cycles with pc_freeze=1, saturating

## Operation
- State: `st` ∈ {RUN, MEM_WAIT}; flag `br_pend`; counter `stall_count`.
- Reset (rst=0): `st`=RUN, `br_pend`=0, `stall_count`=0. All outputs are forced to 0 while rst=0.
- `mem_stall` = (st==RUN & mem_req & ~mem_ready) | (st==MEM_WAIT & ~mem_ready).
- Hazard, fwd_en=0:
  - (src1_vld & exe_wb_en & src1==exe_dest) | (two_src & exe_wb_en & src2==exe_dest), or
  - the same two terms using mem_wb_en/mem_dest.
- Hazard, fwd_en=1: exe_mem_read & exe_wb_en & ((src1_vld & src1==exe_dest) | (two_src & src2==exe_dest)).
- `br` = branch_taken | br_pend.
- Output priority, evaluated per cycle:
  1. mem_stall: pc_freeze = if_id_freeze = pipe_freeze = 1; both flushes 0.
  2. else br: if_id_flush = id_ex_flush = 1; no freezes; the hazard is ignored because the instruction is squashed.
  3. else hazard: pc_freeze = if_id_freeze = 1, id_ex_flush = 1, pipe_freeze = 0.
  4. else all outputs 0.
- FSM transitions:
  - RUN→MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT→RUN on mem_ready.
  - The requester holds mem_req high in MEM_WAIT.
- br_pend:
  - Set when branch_taken & mem_stall.
  - Cleared in the first cycle with mem_stall=0, which is the cycle the flush is issued.
- stall_count increments on every clk edge where pc_freeze=1, and saturates at 2^CNT_W−1.

## Timing
- All freeze/flush outputs are combinational from inputs and state, within the same cycle; no added latency.
- Taken branch in RUN with no mem_stall: flushes in the same cycle.
- Taken branch during MEM_WAIT: flushes in the cycle mem_ready=1 (freeze drops that cycle). This is 0 cycles after release.
- mem_req & mem_ready in the same RUN cycle: no freeze, and the FSM stays in RUN.
- Load-use with fwd_en=1: exactly one stall cycle, because the load leaves EXE.
- Reset asserted in MEM_WAIT: immediate return to RUN and br_pend cleared, asynchronously.

## Test plan
- fwd_en=0, src1=3, src1_vld=1, exe_dest=3, exe_wb_en=1 → pc_freeze=if_id_freeze=id_ex_flush=1, pipe_freeze=0; stall_count 0→1 after the edge.
- fwd_en=1, same match with exe_mem_read=0 → no stall. With exe_mem_read=1 → a one-cycle stall.
- branch_taken=1 with a simultaneous hazard → if_id_flush=id_ex_flush=1, pc_freeze=0, stall_count unchanged.
- mem_req=1 with mem_ready low for 3 cycles:
  - pipe_freeze=1 for 3 cycles and st=MEM_WAIT.
  - mem_ready=1 → all outputs 0 that cycle, then RUN.
  - stall_count +3.
- branch_taken pulses in the 2nd wait cycle → no flush while frozen; if_id_flush=1 in the mem_ready cycle; br_pend=0 afterwards.
- CNT_W=4, hold a hazard for 20 cycles → stall_count sticks at 15. Pull rst low mid-MEM_WAIT → outputs 0, count 0, st=RUN.
